// File: rtl/rxe_pktbuf.sv
// rxe_pktbuf: receive-side packet buffer.
// Bytes from a non-stallable AXI network stream are stored in block RAM.
// A packet is released to the back-pressured AXI stream only after LAST
// arrives without ABORT. Aborted or overflowing packets are rolled back
// to the last commit point and never reach the output.
// Optional: define RXE_PKTBUF_STATS_EN to add 16-bit saturating packet
// counters (good / aborted / overflow).
module rxe_pktbuf #(
  parameter int DW    = 8,
  parameter int LGBUF = 11
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          S_AXIN_VALID,
  output logic          S_AXIN_READY,
  input  logic [DW-1:0] S_AXIN_DATA,
  input  logic          S_AXIN_LAST,
  input  logic          S_AXIN_ABORT,
  output logic          M_AXIS_TVALID,
  input  logic          M_AXIS_TREADY,
  output logic [DW-1:0] M_AXIS_TDATA,
  output logic          M_AXIS_TLAST,
  output logic          o_overflow
`ifdef RXE_PKTBUF_STATS_EN
  ,
  output logic [15:0]   o_pkts_good,
  output logic [15:0]   o_pkts_aborted,
  output logic [15:0]   o_pkts_overflow
`endif
);

  localparam int             DEPTH     = 32'd1 << LGBUF;
  localparam logic [LGBUF:0] PTR_ZERO  = {(LGBUF+1){1'b0}};
  localparam logic [LGBUF:0] PTR_ONE   = {{LGBUF{1'b0}}, 1'b1};
  localparam logic [LGBUF:0] FULL_FILL = {1'b1, {LGBUF{1'b0}}};

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_PKT  = 2'd1,
    W_DROP = 2'd2
  } wstate_t;

  wstate_t        wr_state_r, wr_state_s;
  logic [LGBUF:0] wr_addr_r, wr_addr_s;
  logic [LGBUF:0] wr_commit_r, wr_commit_s;
  logic [LGBUF:0] rd_addr_r;
  logic [LGBUF:0] fill_s;
  logic           full_s;
  logic           drop_abort_r, drop_abort_s;
  logic           mem_we_s;
  logic           overflow_s;
  logic           idle_rules_s;
  logic           rd_issue_s;

  // Bit DW of each word carries the LAST flag of that byte.
  logic [DW:0]    mem_r [0:DEPTH-1];

  // The source is never stalled.
  assign S_AXIN_READY = 1'b1;

  // Occupancy counts committed and in-progress bytes not yet read out;
  // the extra pointer MSB makes wrap-around arithmetic exact.
  assign fill_s = wr_addr_r - rd_addr_r;
  assign full_s = (fill_s == FULL_FILL);

  // Write FSM next state: accept, commit, roll back or discard each beat.
  always_comb begin
    wr_state_s   = wr_state_r;
    wr_addr_s    = wr_addr_r;
    wr_commit_s  = wr_commit_r;
    drop_abort_s = drop_abort_r;
    mem_we_s     = 1'b0;
    overflow_s   = 1'b0;
    idle_rules_s = 1'b0;

    case (wr_state_r)
      W_IDLE: begin
        idle_rules_s = 1'b1;
      end

      W_PKT: begin
        if (S_AXIN_ABORT) begin
          // Abort wins over LAST: rewind to the last commit point.
          wr_addr_s    = wr_commit_r;
          drop_abort_s = 1'b1;
          wr_state_s   = W_DROP;
        end else if (S_AXIN_VALID) begin
          if (full_s) begin
            wr_addr_s  = wr_commit_r;
            overflow_s = 1'b1;
            if (S_AXIN_LAST) begin
              wr_state_s = W_IDLE;
            end else begin
              wr_state_s   = W_DROP;
              drop_abort_s = 1'b0;
            end
          end else begin
            mem_we_s  = 1'b1;
            wr_addr_s = wr_addr_r + PTR_ONE;
            if (S_AXIN_LAST) begin
              wr_commit_s = wr_addr_r + PTR_ONE;
              wr_state_s  = W_IDLE;
            end else begin
              wr_state_s = W_PKT;
            end
          end
        end else begin
          wr_state_s = W_PKT;
        end
      end

      W_DROP: begin
        if (drop_abort_r) begin
          // Leave on the first cycle without ABORT; a beat in that same
          // cycle starts a fresh packet.
          if (!S_AXIN_ABORT) begin
            wr_state_s   = W_IDLE;
            idle_rules_s = 1'b1;
          end else begin
            wr_state_s = W_DROP;
          end
        end else if (S_AXIN_ABORT) begin
          drop_abort_s = 1'b1;
        end else if (S_AXIN_VALID && S_AXIN_LAST) begin
          wr_state_s = W_IDLE;
        end else begin
          wr_state_s = W_DROP;
        end
      end

      default: begin
        wr_state_s = W_IDLE;
        wr_addr_s  = wr_commit_r;
      end
    endcase

    // First-beat handling shared by W_IDLE and the W_DROP exit cycle.
    // Here wr_addr_r always equals wr_commit_r.
    if (idle_rules_s) begin
      if (S_AXIN_VALID && !S_AXIN_ABORT) begin
        if (full_s) begin
          overflow_s = 1'b1;
          wr_addr_s  = wr_commit_r;
          if (S_AXIN_LAST) begin
            wr_state_s = W_IDLE;
          end else begin
            wr_state_s   = W_DROP;
            drop_abort_s = 1'b0;
          end
        end else begin
          mem_we_s  = 1'b1;
          wr_addr_s = wr_addr_r + PTR_ONE;
          if (S_AXIN_LAST) begin
            wr_commit_s = wr_addr_r + PTR_ONE;
            wr_state_s  = W_IDLE;
          end else begin
            wr_state_s = W_PKT;
          end
        end
      end else begin
        wr_state_s = W_IDLE;
      end
    end else begin
      idle_rules_s = 1'b0;
    end
  end

  // Write-side state, pointers and the registered overflow pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_state_r   <= W_IDLE;
      wr_addr_r    <= PTR_ZERO;
      wr_commit_r  <= PTR_ZERO;
      drop_abort_r <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      wr_state_r   <= wr_state_s;
      wr_addr_r    <= wr_addr_s;
      wr_commit_r  <= wr_commit_s;
      drop_abort_r <= drop_abort_s;
      o_overflow   <= overflow_s;
    end
  end

  // Buffer write port; contents need no reset because pointers gate access.
  always_ff @(posedge i_clk) begin
    if (mem_we_s) begin
      mem_r[wr_addr_r[LGBUF-1:0]] <= {S_AXIN_LAST, S_AXIN_DATA};
    end
  end

  // Read only committed data, and only when the output stage is free or
  // draining this cycle.
  assign rd_issue_s = (rd_addr_r != wr_commit_r) &&
                      (!M_AXIS_TVALID || M_AXIS_TREADY);

  // Read pointer and output stage; the RAM read lands directly in the
  // output register, so a stalled beat simply is not reloaded.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_addr_r     <= PTR_ZERO;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= {DW{1'b0}};
      M_AXIS_TLAST  <= 1'b0;
    end else if (rd_issue_s) begin
      rd_addr_r                     <= rd_addr_r + PTR_ONE;
      {M_AXIS_TLAST, M_AXIS_TDATA}  <= mem_r[rd_addr_r[LGBUF-1:0]];
      M_AXIS_TVALID                 <= 1'b1;
    end else if (M_AXIS_TREADY) begin
      M_AXIS_TVALID <= 1'b0;
    end else begin
      M_AXIS_TVALID <= M_AXIS_TVALID;
    end
  end

`ifdef RXE_PKTBUF_STATS_EN
  logic good_evt_s;
  logic abort_evt_s;

  // A commit always moves the commit pointer forward.
  assign good_evt_s  = (wr_commit_s != wr_commit_r);
  // Only an in-progress packet can enter W_DROP through ABORT.
  assign abort_evt_s = (wr_state_r == W_PKT) && S_AXIN_ABORT;

  // Saturating packet statistics.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_pkts_good     <= 16'd0;
      o_pkts_aborted  <= 16'd0;
      o_pkts_overflow <= 16'd0;
    end else begin
      if (good_evt_s && (o_pkts_good != 16'hFFFF)) begin
        o_pkts_good <= o_pkts_good + 16'd1;
      end
      if (abort_evt_s && (o_pkts_aborted != 16'hFFFF)) begin
        o_pkts_aborted <= o_pkts_aborted + 16'd1;
      end
      if (overflow_s && (o_pkts_overflow != 16'hFFFF)) begin
        o_pkts_overflow <= o_pkts_overflow + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rxe_pktbuf.sv
// Directed bench for rxe_pktbuf: a cycle table for short corner cases plus
// hand-written packet sequences. Two instances share the stimulus: one at
// the default depth and one with LGBUF=4 for overflow and wrap cases.
module tb_rxe_pktbuf;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, last, abort, tready;
  logic [7:0] data;

  logic       b_ready, b_tvalid, b_tlast, b_ovf;
  logic [7:0] b_tdata;
  logic       s_ready, s_tvalid, s_tlast, s_ovf;
  logic [7:0] s_tdata;

  int n_vec = 0;
  int n_err = 0;
  int ovf_big = 0;
  int ovf_small = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  rxe_pktbuf #(.DW(8), .LGBUF(11)) dut_big (
    .i_clk(clk), .i_reset(rst),
    .S_AXIN_VALID(valid), .S_AXIN_READY(b_ready), .S_AXIN_DATA(data),
    .S_AXIN_LAST(last), .S_AXIN_ABORT(abort),
    .M_AXIS_TVALID(b_tvalid), .M_AXIS_TREADY(tready),
    .M_AXIS_TDATA(b_tdata), .M_AXIS_TLAST(b_tlast), .o_overflow(b_ovf)
  );

  rxe_pktbuf #(.DW(8), .LGBUF(4)) dut_small (
    .i_clk(clk), .i_reset(rst),
    .S_AXIN_VALID(valid), .S_AXIN_READY(s_ready), .S_AXIN_DATA(data),
    .S_AXIN_LAST(last), .S_AXIN_ABORT(abort),
    .M_AXIS_TVALID(s_tvalid), .M_AXIS_TREADY(tready),
    .M_AXIS_TDATA(s_tdata), .M_AXIS_TLAST(s_tlast), .o_overflow(s_ovf)
  );

  // Count overflow pulses seen on each instance.
  always @(posedge clk) begin
    if (b_ovf) ovf_big <= ovf_big + 1;
    if (s_ovf) ovf_small <= ovf_small + 1;
  end

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       abort;
    logic       tready;
    logic       e_tvalid;
    logic       chk_data;
    logic [7:0] e_tdata;
    logic       e_tlast;
  } vec_t;

  vec_t tab [20];

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic l, input logic a, input logic tr,
                              input logic ev, input logic ec,
                              input logic [7:0] ed, input logic el);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.last = l; t.abort = a;
    t.tready = tr; t.e_tvalid = ev; t.chk_data = ec; t.e_tdata = ed;
    t.e_tlast = el;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid = 1'b0; data = 8'h00; last = 1'b0; abort = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tready = 1'b0; idle_in();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic a);
    valid = 1'b1; data = d; last = l; abort = a;
    tick();
  endtask

  function automatic logic [9:0] cur(input bit sel);
    return sel ? {s_tvalid, s_tlast, s_tdata} : {b_tvalid, b_tlast, b_tdata};
  endfunction

  // Drain with TREADY=1 for a fixed window, comparing against exp_q and
  // flagging missing or extra beats.
  task automatic collect(input bit sel, input int budget, input string name);
    int got;
    logic [9:0] o;
    got = 0;
    tready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      o = cur(sel);
      if (o[9]) begin
        if (got < exp_q.size()) check(name, {23'd0, o[8:0]}, {23'd0, exp_q[got]});
        got++;
      end
      tick();
    end
    check({name, "_count"}, got, exp_q.size());
  endtask

  initial begin
    int early;
    int base;

    rst = 1'b1; tready = 1'b0; idle_in();

    // Cycle table: reset, three 1-byte packets under toggling TREADY,
    // lone ABORT, ABORT+LAST together, and the W_DROP exit beat.
    tab[0]  = mk(1, 0, 8'h00, 0, 0, 0,  0, 1, 8'h00, 0);
    tab[1]  = mk(0, 1, 8'h11, 1, 0, 0,  0, 0, 8'h00, 0);
    tab[2]  = mk(0, 1, 8'h22, 1, 0, 0,  1, 1, 8'h11, 1);
    tab[3]  = mk(0, 1, 8'h33, 1, 0, 0,  1, 1, 8'h11, 1);
    tab[4]  = mk(0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h22, 1);
    tab[5]  = mk(0, 0, 8'h00, 0, 0, 0,  1, 1, 8'h22, 1);
    tab[6]  = mk(0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h33, 1);
    tab[7]  = mk(0, 0, 8'h00, 0, 0, 0,  1, 1, 8'h33, 1);
    tab[8]  = mk(0, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0);
    tab[9]  = mk(0, 0, 8'h00, 0, 1, 1,  0, 0, 8'h00, 0);
    tab[10] = mk(0, 1, 8'h77, 1, 1, 1,  0, 0, 8'h00, 0);
    tab[11] = mk(0, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0);
    tab[12] = mk(0, 1, 8'h44, 1, 0, 1,  0, 0, 8'h00, 0);
    tab[13] = mk(0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h44, 1);
    tab[14] = mk(0, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0);
    tab[15] = mk(0, 1, 8'h55, 0, 0, 1,  0, 0, 8'h00, 0);
    tab[16] = mk(0, 1, 8'h56, 1, 1, 1,  0, 0, 8'h00, 0);
    tab[17] = mk(0, 1, 8'h66, 1, 0, 1,  0, 0, 8'h00, 0);
    tab[18] = mk(0, 0, 8'h00, 0, 0, 1,  1, 1, 8'h66, 1);
    tab[19] = mk(0, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0);

    for (int i = 0; i < 20; i++) begin
      rst = tab[i].rst; valid = tab[i].valid; data = tab[i].data;
      last = tab[i].last; abort = tab[i].abort; tready = tab[i].tready;
      tick();
      check($sformatf("tab%0d_tvalid", i), b_tvalid, tab[i].e_tvalid);
      if (tab[i].chk_data) begin
        check($sformatf("tab%0d_tdata", i), b_tdata, tab[i].e_tdata);
        check($sformatf("tab%0d_tlast", i), b_tlast, tab[i].e_tlast);
      end
      check($sformatf("tab%0d_ovf", i), b_ovf, 1'b0);
    end
    check("ready_const", b_ready, 1'b1);

    // 64-byte packet: no early output, TVALID two cycles after LAST.
    do_reset();
    tready = 1'b1;
    early = 0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      send_beat(8'(i), (i == 63), 1'b0);
      exp_q.push_back({(i == 63), 8'(i)});
      if (b_tvalid) early++;
    end
    idle_in();
    check("t1_no_early", early, 0);
    tick();
    check("t1_latency_tvalid", b_tvalid, 1'b1);
    check("t1_first_data", b_tdata, 8'h00);
    collect(1'b0, 80, "t1_data");

    // Aborted 10-byte packet then a 4-byte packet A0..A3.
    do_reset();
    for (int i = 0; i < 10; i++) send_beat(8'h50 + 8'(i), (i == 9), (i >= 5));
    idle_in();
    tick();
    check("t2_wr_addr_restored", dut_big.wr_addr_r, 32'd0);
    check("t2_no_output", b_tvalid, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      send_beat(8'hA0 + 8'(i), (i == 3), 1'b0);
      exp_q.push_back({(i == 3), 8'hA0 + 8'(i)});
    end
    idle_in();
    collect(1'b0, 20, "t2_data");
    check("t2_wr_addr_after", dut_big.wr_addr_r, 32'd4);

    // LGBUF=4 overflow: 12 bytes commit, following 8 bytes drop once.
    do_reset();
    base = ovf_small;
    for (int i = 0; i < 12; i++) send_beat(8'h80 + 8'(i), (i == 11), 1'b0);
    for (int i = 0; i < 8; i++) send_beat(8'hC0 + 8'(i), (i == 7), 1'b0);
    idle_in();
    tick(); tick();
    check("t3_ovf_pulses", ovf_small - base, 1);
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back({(i == 11), 8'h80 + 8'(i)});
    collect(1'b1, 40, "t3_data");

    // LGBUF=4 pointer wrap: 40 packets of 7 bytes streamed through.
    do_reset();
    base = ovf_small;
    exp_q.delete();
    for (int p = 0; p < 40; p++)
      for (int b = 0; b < 7; b++) exp_q.push_back({(b == 6), 8'(p * 7 + b)});
    tready = 1'b1;
    fork
      begin
        for (int p = 0; p < 40; p++)
          for (int b = 0; b < 7; b++) send_beat(8'(p * 7 + b), (b == 6), 1'b0);
        idle_in();
      end
      collect(1'b1, 400, "t5_data");
    join
    check("t5_no_ovf", ovf_small - base, 0);

    // Reset in the middle of readout, then a fresh packet.
    do_reset();
    for (int i = 0; i < 20; i++) send_beat(8'h60 + 8'(i), (i == 19), 1'b0);
    idle_in();
    tready = 1'b1;
    tick(); tick(); tick();
    check("t6_mid_readout", b_tvalid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_tvalid", b_tvalid, 1'b0);
    check("t6_rst_tdata", b_tdata, 8'h00);
    early = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b_tvalid) early++;
    end
    check("t6_empty_after", early, 0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      send_beat(8'h71 + 8'(i), (i == 2), 1'b0);
      exp_q.push_back({(i == 2), 8'h71 + 8'(i)});
    end
    idle_in();
    collect(1'b0, 20, "t6_new_pkt");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
